pipe_shifter: RTL and testbench
===============================

// Module: pipe_shifter
// PURPOSE
//   Parametrised, pipelined log-shifter for the execute stage. It replaces the
//   single-cycle 32-bit SLL/SRA unit for multicycle shift ops.
//   Has one registered stage per shift-amount bit, valid/ready handshakes at both
//   ends and a per-op tag, so the ALU can issue back-to-back shifts and stall.
//   Adds SRL mode and an optional rotate-left mode.
// PARAMETERS
//   WIDTH   32                  data width; power of two, >= 4
//   SHAMT_W $clog2(WIDTH)       shift-amount width; also the number of pipeline stages
//   TAG_W   5                   width of the opaque tag (e.g. destination reg); carried unchanged
// PORTS
//   clock      in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high
//   flush      in   1        synchronous; kills every in-flight op
//   in_valid   in   1        op presented this cycle
//   in_ready   out  1        shifter accepts the op this cycle
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag     in   TAG_W    tag
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts the result
//   out_data   out  WIDTH    shifted result
//   out_tag    out  TAG_W    tag of the result
// BEHAVIOUR
//   - Stage k (k = 0..SHAMT_W-1) applies a shift of 2^(SHAMT_W-1-k) when the
//     corresponding shamt bit is set. Shift order is MSB first.
//   - Each stage registers data, the remaining shamt bits, op, tag and a valid bit.
//   - Latency: SHAMT_W cycles from accept (in_valid & in_ready) to out_valid.
//     With WIDTH=32 this is 5 cycles.
//   - Throughput: 1 op per cycle while out_ready=1.
//   - Advance rule: stage k loads when it is empty or stage k+1 loads (or the op
//     leaves at the output) in that cycle.
//     in_ready = !v[0] | load[1]. This is combinational, so bubbles collapse.
//   - Output: out_* come straight from the last stage's register. The result
//     leaves on out_valid & out_ready.
//     While out_ready=0, out_data and out_tag hold stable.
//   - Arithmetic per mode:
//       SLL: zero-fill from the LSB.
//       SRL: zero-fill from the MSB.
//       SRA: fill with the operand's original bit WIDTH-1.
//       ROL: bits wrap from the MSB to the LSB.
//       shamt=0 passes the data unchanged in every mode.
//   - Reset: all valid bits = 0 and out_valid = 0. in_ready = 1 as soon as reset
//     deasserts. Data and tag registers clear to 0, so out_data = 0 and out_tag = 0.
//     Reset mid-operation discards every in-flight op with no partial output.
//   - flush: at the next edge all valid bits = 0, and no op accepted in that
//     cycle enters (in_ready is still driven normally).
//     flush has priority over accept.
//   - Simultaneous accept and output: both occur when the pipe is full and
//     out_ready=1. Occupancy stays SHAMT_W.
//   - Full pipe with out_ready=0: in_ready=0 and no state changes.
// CONFIGURATION
//   PIPE_SHIFTER_ROTATE_EN
//     defined:   op 11 = ROL, as above.
//     undefined: no rotate logic is built and op 11 behaves exactly as SLL.
// STRUCTURE
//   - package shift_pkg: op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10,
//     OP_ROL=2'b11, and a function clog2 for SHAMT_W.
//   - Sub-module shift_stage #(WIDTH, TAG_W, AMT): one registered fixed-amount
//     stage holding the mode mux, sign bit and handshake logic.
//     pipe_shifter is a generate loop of SHAMT_W shift_stage instances plus the
//     in_ready/out glue.
// TESTING
//   1. SLL 0x00000001 shamt 31 tag 3, out_ready=1 -> after 5 cycles
//      out_data=0x80000000, out_tag=3, with one out_valid pulse.
//   2. SRA 0x80000000 shamt 4 -> 0xF8000000.
//      SRL 0x80000000 shamt 4 -> 0x08000000.
//      shamt 0 -> operand unchanged.
//   3. Stream 8 back-to-back ops with out_ready=1 -> results in order on 8
//      consecutive cycles; in_ready never drops.
//   4. Hold out_ready=0 after 5 accepts -> in_ready=0, out_data stable.
//      Release -> one result per cycle, none lost or duplicated.
//   5. flush with 3 ops in flight and in_valid=1 -> out_valid stays 0 for the
//      next 5 cycles; the next op completes normally.
//      Async reset mid-stream gives the same result.
//   6. ROL 0x80000001 shamt 1 -> 0x00000003 with PIPE_SHIFTER_ROTATE_EN defined,
//      and 0x00000002 without it.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: op encodings and the
// ceiling-log2 helper that sizes the shift-amount field / stage count.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Operand/result bus of the pipelined shifter.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer that raises valid keeps its payload stable until
// that edge; ready may depend combinationally on the downstream ready.
// The master is the issuing ALU side, the slave is the shifter.
interface pipe_shifter_if
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = clog2(WIDTH),
  parameter int TAG_W   = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/shift_stage.sv
// One registered pipeline stage of the log-shifter: applies a fixed shift of
// AMT positions when its shamt bit is set, in the mode carried with the op.
// Build option: PIPE_SHIFTER_ROTATE_EN adds rotate-left for op 11; without it
// op 11 takes the SLL path.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = 5,
  parameter int AMT     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [1:0]         up_op,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               down_valid,
  output logic [WIDTH-1:0]   down_data,
  output logic [SHAMT_W-1:0] down_shamt,
  output logic [1:0]         down_op,
  output logic [TAG_W-1:0]   down_tag
);

  localparam int BIT = clog2(AMT);

  logic [WIDTH-1:0] shifted;

  // Mode mux for this stage's fixed amount. SRA keeps the MSB of every
  // intermediate value equal to the operand's original sign bit, so the
  // incoming MSB is the correct fill at every stage.
  always_comb begin
    shifted = up_data;
    if (up_shamt[BIT]) begin
      case (shift_op_e'(up_op))
        OP_SRL:  shifted = up_data >> AMT;
        OP_SRA:  shifted = $signed(up_data) >>> AMT;
`ifdef PIPE_SHIFTER_ROTATE_EN
        OP_ROL:  shifted = (up_data << AMT) | (up_data >> (WIDTH - AMT));
`endif
        default: shifted = up_data << AMT;
      endcase
    end
  end

  // Stage register: valid follows the advance/flush rule, payload only
  // updates when a real op moves in so a stalled output stays put.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_shamt <= '0;
      down_op    <= '0;
      down_tag   <= '0;
    end else begin
      if (flush) begin
        down_valid <= 1'b0;
      end else if (load) begin
        down_valid <= up_valid;
      end
      if (load && up_valid) begin
        down_data  <= shifted;
        down_shamt <= up_shamt;
        down_op    <= up_op;
        down_tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined log-shifter (SLL/SRL/SRA, optional ROL) with one registered
// stage per shift-amount bit, MSB first, and valid/ready at both ends.
// Build option: PIPE_SHIFTER_ROTATE_EN enables rotate-left on op 11.
module pipe_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  pipe_shifter_if.slave  bus
);

  // Slot 0 is the input port; slot k+1 is the register of stage k.
  logic [SHAMT_W:0]   s_valid;
  logic [WIDTH-1:0]   s_data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] s_shamt [SHAMT_W+1];
  logic [1:0]         s_op    [SHAMT_W+1];
  logic [TAG_W-1:0]   s_tag   [SHAMT_W+1];
  logic [SHAMT_W-1:0] s_load;

  assign s_valid[0] = bus.in_valid;
  assign s_data[0]  = bus.in_data;
  assign s_shamt[0] = bus.in_shamt;
  assign s_op[0]    = bus.in_op;
  assign s_tag[0]   = bus.in_tag;

  // Advance chain from the output backwards: a stage loads when it is empty
  // or everything after it moves, so bubbles collapse within one cycle.
  always_comb begin
    logic adv;
    s_load = '0;
    adv    = bus.out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      adv       = adv | ~s_valid[k+1];
      s_load[k] = adv;
    end
  end

  assign bus.in_ready  = s_load[0];
  assign bus.out_valid = s_valid[SHAMT_W];
  assign bus.out_data  = s_data[SHAMT_W];
  assign bus.out_tag   = s_tag[SHAMT_W];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .SHAMT_W (SHAMT_W),
      .AMT     (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .load       (s_load[k]),
      .up_valid   (s_valid[k]),
      .up_data    (s_data[k]),
      .up_shamt   (s_shamt[k]),
      .up_op      (s_op[k]),
      .up_tag     (s_tag[k]),
      .down_valid (s_valid[k+1]),
      .down_data  (s_data[k+1]),
      .down_shamt (s_shamt[k+1]),
      .down_op    (s_op[k+1]),
      .down_tag   (s_tag[k+1])
    );
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed testbench for pipe_shifter (32-bit, 5 stages).
module tb_pipe_shifter;
  import shift_pkg::*;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;
  localparam int N_MODE  = 15;

`ifdef PIPE_SHIFTER_ROTATE_EN
  localparam logic [WIDTH-1:0] ROL_A = 32'h0000_0003;
  localparam logic [WIDTH-1:0] ROL_B = 32'h2345_6781;
  localparam logic [WIDTH-1:0] ROL_C = 32'h0000_00FF;
`else
  localparam logic [WIDTH-1:0] ROL_A = 32'h0000_0002;
  localparam logic [WIDTH-1:0] ROL_B = 32'h2345_6780;
  localparam logic [WIDTH-1:0] ROL_C = 32'h0000_00F0;
`endif

  localparam logic [WIDTH-1:0] MODE_D [N_MODE] = '{
    32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0001,
    32'hF0F0_F0F0, 32'h7FFF_FFFF, 32'h8000_0001, 32'h1234_5678, 32'h1234_5678,
    32'h9000_0000, 32'h8000_0001, 32'h1234_5678, 32'h8765_4321, 32'hF000_000F};
  localparam logic [SHAMT_W-1:0] MODE_S [N_MODE] = '{
    5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd8, 5'd12,
    5'd3, 5'd1, 5'd4, 5'd21, 5'd4};
  localparam logic [1:0] MODE_O [N_MODE] = '{
    2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01,
    2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
  localparam logic [WIDTH-1:0] MODE_E [N_MODE] = '{
    32'hF800_0000, 32'h0800_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0001,
    32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h3456_7800, 32'h0001_2345,
    32'hF200_0000, ROL_A, ROL_B, 32'hFFFF_FC3B, ROL_C};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic [WIDTH-1:0] got_data_q[$];
  logic [TAG_W-1:0] got_tag_q[$];
  int               got_cyc_q[$];

  pipe_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) bus ();

  pipe_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: records every result transfer with its edge count
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_data_q.push_back(bus.out_data);
      got_tag_q.push_back(bus.out_tag);
      got_cyc_q.push_back(cyc + 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_sb();
    exp_q.delete();
    exp_tag_q.delete();
    got_data_q.delete();
    got_tag_q.delete();
    got_cyc_q.delete();
  endtask

  // Wait n edges, returning 1 time unit after the last one
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one op and hold it until accepted (bounded). Called 1 unit after
  // an edge; returns 1 unit after the accepting edge with acc = that edge count.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh,
                      input logic [1:0] op, input logic [TAG_W-1:0] tg,
                      output int stalls, output int acc);
    int  budget;
    bit  done;
    budget = 40;
    done   = 1'b0;
    stalls = 0;
    acc    = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_op    = op;
    bus.in_tag   = tg;
    while (!done && budget > 0) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) done = 1'b1;
      else stalls++;
      @(posedge clock);
      #1;
      budget--;
    end
    if (done) begin
      acc = cyc;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1 within 40 cycles", bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data); end
    n_checks++;
    if (bus.out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d expected 0", bus.out_tag); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_sll_basic();
    int st, acc;
    logic [WIDTH-1:0] g;
    logic [TAG_W-1:0] gt;
    int gc;
    clear_sb();
    bus.out_ready = 1'b1;
    send(32'h0000_0001, 5'd31, OP_SLL, 5'd3, st, acc);
    wait_cycles(12);
    n_checks++;
    if (got_data_q.size() !== 1) begin n_fail++; $display("FAIL sll_pulse_count: got %0d results expected 1", got_data_q.size()); end
    g = 'x; gt = 'x; gc = -100;
    if (got_data_q.size() > 0) begin g = got_data_q[0]; gt = got_tag_q[0]; gc = got_cyc_q[0]; end
    n_checks++;
    if (g !== 32'h8000_0000) begin n_fail++; $display("FAIL sll_data: got %h expected 80000000", g); end
    n_checks++;
    if (gt !== 5'd3) begin n_fail++; $display("FAIL sll_tag: got %0d expected 3", gt); end
    n_checks++;
    if (gc !== acc + SHAMT_W) begin n_fail++; $display("FAIL sll_latency: got %0d edges expected %0d", gc - acc, SHAMT_W); end
  endtask

  task automatic test_modes();
    int st, acc;
    logic [WIDTH-1:0] e, g;
    logic [TAG_W-1:0] et, gt;
    clear_sb();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N_MODE; i++) begin
      send(MODE_D[i], MODE_S[i], MODE_O[i], TAG_W'(i), st, acc);
      exp_q.push_back(MODE_E[i]);
      exp_tag_q.push_back(TAG_W'(i));
    end
    wait_cycles(12);
    for (int i = 0; i < N_MODE; i++) begin
      e = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      g = 'x; gt = 'x;
      if (got_data_q.size() > 0) begin g = got_data_q.pop_front(); gt = got_tag_q.pop_front(); end
      n_checks++;
      if (g !== e || gt !== et) begin
        n_fail++;
        $display("FAIL mode_vec%0d: got %h tag %0d expected %h tag %0d", i, g, gt, e, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st, acc, total_stalls;
    logic [WIDTH-1:0] e, g;
    logic [TAG_W-1:0] et, gt;
    int c0;
    clear_sb();
    bus.out_ready = 1'b1;
    total_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'h8000_0000, SHAMT_W'(i), OP_SRL, TAG_W'(16 + i), st, acc);
      total_stalls += st;
      exp_q.push_back(32'h8000_0000 >> i);
      exp_tag_q.push_back(TAG_W'(16 + i));
    end
    wait_cycles(10);
    n_checks++;
    if (total_stalls !== 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d stall cycles expected 0", total_stalls); end
    n_checks++;
    if (got_data_q.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 8", got_data_q.size()); end
    c0 = (got_cyc_q.size() > 0) ? got_cyc_q[0] : 0;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      g = 'x; gt = 'x;
      if (got_data_q.size() > 0) begin
        g = got_data_q.pop_front();
        gt = got_tag_q.pop_front();
        n_checks++;
        if (got_cyc_q[0] !== c0 + i) begin n_fail++; $display("FAIL b2b_spacing%0d: got edge %0d expected %0d", i, got_cyc_q[0], c0 + i); end
        void'(got_cyc_q.pop_front());
      end
      n_checks++;
      if (g !== e || gt !== et) begin
        n_fail++;
        $display("FAIL b2b_res%0d: got %h tag %0d expected %h tag %0d", i, g, gt, e, et);
      end
    end
  endtask

  task automatic test_backpressure();
    int st, acc, total_stalls, c0;
    logic [WIDTH-1:0] e, g;
    logic [TAG_W-1:0] et, gt;
    clear_sb();
    bus.out_ready = 1'b0;
    total_stalls = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_00FF, SHAMT_W'(4 * i), OP_SLL, TAG_W'(20 + i), st, acc);
      total_stalls += st;
      exp_q.push_back(32'h0000_00FF << (4 * i));
      exp_tag_q.push_back(TAG_W'(20 + i));
    end
    n_checks++;
    if (total_stalls !== 0) begin n_fail++; $display("FAIL bp_fill_stalls: got %0d expected 0", total_stalls); end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA_5555;
    bus.in_shamt = 5'd1;
    bus.in_op    = OP_SLL;
    bus.in_tag   = 5'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid%0d: got %b expected 1", i, bus.out_valid); end
      n_checks++;
      if (bus.out_data !== 32'h0000_00FF || bus.out_tag !== 5'd20) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h tag %0d expected 000000ff tag 20", i, bus.out_data, bus.out_tag);
      end
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_cycles(10);
    n_checks++;
    if (got_data_q.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d results expected 5", got_data_q.size()); end
    c0 = (got_cyc_q.size() > 0) ? got_cyc_q[0] : 0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      g = 'x; gt = 'x;
      if (got_data_q.size() > 0) begin
        g = got_data_q.pop_front();
        gt = got_tag_q.pop_front();
        n_checks++;
        if (got_cyc_q[0] !== c0 + i) begin n_fail++; $display("FAIL bp_spacing%0d: got edge %0d expected %0d", i, got_cyc_q[0], c0 + i); end
        void'(got_cyc_q.pop_front());
      end
      n_checks++;
      if (g !== e || gt !== et) begin
        n_fail++;
        $display("FAIL bp_res%0d: got %h tag %0d expected %h tag %0d", i, g, gt, e, et);
      end
    end
  endtask

  // Kill three in-flight ops either with flush (use_reset=0) or async reset
  task automatic test_kill(input bit use_reset);
    int st, acc;
    logic [WIDTH-1:0] g;
    logic [TAG_W-1:0] gt;
    clear_sb();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h0000_0F0F, 5'd2, OP_SLL, TAG_W'(1 + i), st, acc);
    if (use_reset) begin
      #2;
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 5'd0) begin
        n_fail++;
        $display("FAIL rst_mid_clear: got valid %b data %h tag %0d expected 0 0 0", bus.out_valid, bus.out_data, bus.out_tag);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
    end else begin
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1111_1111;
      bus.in_shamt = 5'd0;
      bus.in_op    = OP_SLL;
      bus.in_tag   = 5'd7;
      @(negedge clock);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
      @(posedge clock);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kill%0d_quiet%0d: out_valid got %b expected 0", use_reset, i, bus.out_valid); end
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (got_data_q.size() !== 0) begin n_fail++; $display("FAIL kill%0d_leak: got %0d results expected 0", use_reset, got_data_q.size()); end
    send(32'hF000_0000, 5'd28, OP_SRL, 5'd9, st, acc);
    wait_cycles(8);
    g = 'x; gt = 'x;
    if (got_data_q.size() > 0) begin g = got_data_q[0]; gt = got_tag_q[0]; end
    n_checks++;
    if (got_data_q.size() !== 1 || g !== 32'h0000_000F || gt !== 5'd9) begin
      n_fail++;
      $display("FAIL kill%0d_after: got %0d results first %h tag %0d expected 1 result 0000000f tag 9", use_reset, got_data_q.size(), g, gt);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sll_basic();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_kill(1'b0);
    test_kill(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
